// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder: req/ready handshake, wait states, sub-word access
// Request fields are captured on accept; the response is registered when leaving RESP.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        range_err, f3_err, align_err, err_d;
  logic [31:0] rd_word, byte_sh, load_val, rdata_d;
  logic [15:0] half_sel;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic        wr_en;

  always_comb begin
    off       = addr_q - BASE_ADDR;
    idx       = off[AW+1:2];
    range_err = (off[31:2] >= 30'(DEPTH_WORDS));
    if (we_q) f3_err = f3_q[2] | (f3_q[1:0] == 2'b11);
    else      f3_err = (f3_q == 3'b011) | (f3_q[2:1] == 2'b11);
    align_err = ((f3_q[1:0] == 2'b01) & off[0]) |
                ((f3_q[1:0] == 2'b10) & (off[1:0] != 2'b00));
    err_d     = range_err | f3_err | align_err;

    rd_word  = mem[idx];
    byte_sh  = rd_word >> {off[1:0], 3'b000};
    half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_val = {24'h0, byte_sh[7:0]};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      3'b010:  load_val = rd_word;
      default: load_val = 32'h0;
    endcase
    rdata_d = (err_d | we_q) ? 32'h0 : load_val;

    // Byte-lane enables; store data is replicated so every enabled lane sees its slice.
    case (f3_q[1:0])
      2'b00:   begin be = 4'b0001 << off[1:0];              wlane = {4{wdata_q[7:0]}};  end
      2'b01:   begin be = off[1] ? 4'b1100 : 4'b0011;        wlane = {2{wdata_q[15:0]}}; end
      default: begin be = 4'b1111;                           wlane = wdata_q;            end
    endcase
    wr_en = (state_q == S_RESP) & we_q & ~err_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          if (mem_req) begin
            we_q    <= mem_we;
            f3_q    <= mem_funct3;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            cnt_q   <= 4'(WAIT_STATES - 1);
            state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP: begin
          ready_q <= 1'b1;
          rdata_q <= rdata_d;
          err_q   <= err_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
// Drives a WAIT_STATES=1 instance and a WAIT_STATES=0 instance from one linear sequence.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        ready, err;
  logic [31:0] rdata;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [2:0]  f3_0 = 3'd0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
  logic        ready0, err0;
  logic [31:0] rdata0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [256];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_we(we), .mem_funct3(f3),
    .mem_addr(addr), .mem_wdata(wdata), .mem_ready(ready), .mem_rdata(rdata), .mem_err(err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .mem_req(req0), .mem_we(we0), .mem_funct3(f3_0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_ready(ready0), .mem_rdata(rdata0), .mem_err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fill(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  // One request; inputs are scrambled after the accept edge to prove they were captured.
  task automatic txn(input string tag, input bit sel, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        e;
    int          cyc;
    bit          got;
    rd = '1; e = 1'bx; cyc = 0; got = 1'b0;
    @(negedge clk);
    if (!sel) begin req = 1'b1; we = w; f3 = f; addr = a; wdata = d; end
    else begin req0 = 1'b1; we0 = w; f3_0 = f; addr0 = a; wdata0 = d; end
    while (!got && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (sel ? ready0 : ready) begin
        got = 1'b1;
        rd  = sel ? rdata0 : rdata;
        e   = sel ? err0 : err;
      end else if (cyc == 1) begin
        addr = ~addr; wdata = ~wdata; f3 = f3 ^ 3'b001;
        addr0 = ~addr0; wdata0 = ~wdata0; f3_0 = f3_0 ^ 3'b001;
      end
    end
    req = 1'b0; req0 = 1'b0;
    chk($sformatf("%s.lat", tag), got ? 32'(cyc - 1) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk($sformatf("%s.rdata", tag), rd, exp_rd);
    chk($sformatf("%s.err", tag), {31'h0, e}, {31'h0, exp_err});
    @(posedge clk); #1;
    chk($sformatf("%s.pulse", tag), {31'h0, sel ? ready0 : ready}, 32'h0);
  endtask

  initial begin
    int pulses, consec;
    logic prev;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", {31'h0, ready}, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.err",   {31'h0, err}, 32'h0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 256; i++) begin
      model[i] = fill(i);
      txn("fill", 1'b0, 1'b1, 3'b010, 32'(i * 4), model[i], 32'h0, 1'b0, 2);
    end

    txn("t1.sw", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    model[4] = 32'hDEAD_BEEF;
    txn("t1.lw", 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

    txn("t2.sb",  1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFF_FF5A, 32'h0, 1'b0, 2);
    model[4] = 32'hDEAD_5AEF;
    txn("t2.lw",  1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0, 2);
    txn("t2.lb",  1'b0, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 2);
    txn("t2.lbu", 1'b0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 2);
    txn("t2.lb0", 1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0, 2);
    txn("t2.lbu1",1'b0, 1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_005A, 1'b0, 2);

    txn("t3.lh",  1'b0, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 2);
    txn("t3.lhu", 1'b0, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0, 2);
    txn("t3.lhmis", 1'b0, 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 2);
    txn("t3.lh0", 1'b0, 1'b0, 3'b001, 32'h10, 32'h0, 32'h0000_5AEF, 1'b0, 2);

    txn("t3.sh",  1'b0, 1'b1, 3'b001, 32'h12, 32'h1234_CAFE, 32'h0, 1'b0, 2);
    model[4] = 32'hCAFE_5AEF;
    txn("t3.lwsh",1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE_5AEF, 1'b0, 2);

    txn("t4.swmis",  1'b0, 1'b1, 3'b010, 32'h402, 32'h1234_5678, 32'h0, 1'b1, 2);
    txn("t4.swoor",  1'b0, 1'b1, 3'b010, 32'h400, 32'h1234_5678, 32'h0, 1'b1, 2);
    txn("t4.swmis2", 1'b0, 1'b1, 3'b010, 32'h22,  32'h1234_5678, 32'h0, 1'b1, 2);
    txn("t4.shmis",  1'b0, 1'b1, 3'b001, 32'h25,  32'h1234_5678, 32'h0, 1'b1, 2);
    txn("t4.lwoor",  1'b0, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 2);
    txn("t4.lbwrap", 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 2);
    txn("t4.ld011",  1'b0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 2);
    txn("t4.ld110",  1'b0, 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 2);
    txn("t4.st100",  1'b0, 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 2);
    txn("t4.st101",  1'b0, 1'b1, 3'b101, 32'h14, 32'h0, 32'h0, 1'b1, 2);
    for (int i = 0; i < 256; i++)
      txn("t4.scan", 1'b0, 1'b0, 3'b010, 32'(i * 4), 32'h0, model[i], 1'b0, 2);

    // Reset lands while the store sits in WAIT.
    @(negedge clk);
    req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h20; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(negedge clk) rst = 1'b0;
    #1 chk("t5.rst_ready", {31'h0, ready}, 32'h0);
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    prev = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      prev = prev | ready;
    end
    chk("t5.no_pulse", {31'h0, prev}, 32'h0);
    txn("t5.lwold", 1'b0, 1'b0, 3'b010, 32'h20, 32'h0, model[8], 1'b0, 2);

    txn("t5.ws0.sw", 1'b1, 1'b1, 3'b010, 32'h40, 32'h0BAD_F00D, 32'h0, 1'b0, 1);
    txn("t5.ws0.lw", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0BAD_F00D, 1'b0, 1);
    txn("t5.ws0.lbu",1'b1, 1'b0, 3'b100, 32'h42, 32'h0, 32'h0000_00AD, 1'b0, 1);

    // mem_req held high: one pulse every 3 cycles, never two in a row.
    @(negedge clk);
    req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h30; wdata = 32'h1122_3344;
    pulses = 0; consec = 0; prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
      if (ready && prev) consec++;
      prev = ready;
    end
    @(negedge clk) req = 1'b0;
    repeat (4) @(posedge clk);
    model[12] = 32'h1122_3344;
    chk("t6.pulses", 32'(pulses), 32'd4);
    chk("t6.consec", 32'(consec), 32'd0);
    txn("t6.lw", 1'b0, 1'b0, 3'b010, 32'h30, 32'h0, 32'h1122_3344, 1'b0, 2);
    txn("t6.nb", 1'b0, 1'b0, 3'b010, 32'h34, 32'h0, model[13], 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
